// File: rtl/uart_boot_loader_if.sv
// Bundles the UART receive handshake, the instruction-memory write port and the loader status lines.
// Purely combinational: it carries signals and adds no latency.
// The loader consumes a UART byte only by pulsing rxClear; the memory port is write-only and cannot stall.
//
// Signals:
//   rxReady, rxData     : UART byte-available flag and the byte itself (driven by the UART side)
//   rxClear             : one-cycle pulse from the loader that consumes the current byte
//   instWren,
//   instAddress,
//   instData            : instruction-memory write strobe, word address and word
//   cpuHold, done, error: CPU stall request and load status
interface uart_boot_loader_if #(
    parameter int ADDR_SIZE = 10
);
    logic                 rxReady;
    logic [7:0]           rxData;
    logic                 rxClear;
    logic                 instWren;
    logic [ADDR_SIZE-1:0] instAddress;
    logic [31:0]          instData;
    logic                 cpuHold;
    logic                 done;
    logic                 error;

    // Loader side.
    modport master (
        input  rxReady, rxData,
        output rxClear, instWren, instAddress, instData, cpuHold, done, error
    );

    // UART / memory / CPU side.
    modport slave (
        output rxReady, rxData,
        input  rxClear, instWren, instAddress, instData, cpuHold, done, error
    );
endinterface

// File: rtl/uart_boot_loader.sv
// Serial program loader: takes a framed image from the UART, writes big-endian words into instruction memory,
// and releases the CPU only once the checksum matches.
// Latency: each byte is consumed one cycle after it is seen (rxClear); a word is written the cycle after its 4th byte.
// Backpressure: a byte is accepted only when rxReady=1 and no rxClear is pending, so the loader accepts at most every other cycle.
//
// Ports:
//   clk  : single clock domain
//   rst  : asynchronous active-low reset
//   bus  : uart_boot_loader_if.master (UART byte handshake, instruction-memory write port, cpuHold/done/error)
//
// Frame: SYNC_BYTE, N[15:8], N[7:0], 4*N data bytes (MSB first per word), XOR checksum of the data bytes.
module uart_boot_loader #(
    parameter int          ADDR_SIZE      = 10,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    uart_boot_loader_if.master bus
);

    localparam int              TO_W      = $clog2(TIMEOUT_CYCLES + 1);
    // The counter holds (cycles since last byte - 1), so this value means the limit is reached this cycle.
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0]     MAX_WORDS = 17'(1) << ADDR_SIZE;

    typedef enum logic [2:0] {
        WAIT_SYNC,
        LEN_HI,
        LEN_LO,
        DATA,
        CHKSUM,
        DONE,
        ERROR
    } state_t;

    state_t               state, stateNext;

    logic [7:0]           lenHi, lenHiNext;
    logic [15:0]          wordCnt, wordCntNext;
    // One bit wider than the address so a full-memory image (N = 2**ADDR_SIZE) can be counted.
    logic [ADDR_SIZE:0]   wordIdx, wordIdxNext;
    logic [1:0]           byteCnt, byteCntNext;
    logic [23:0]          shiftReg, shiftNext;
    logic [7:0]           checksum, checksumNext;
    logic [TO_W-1:0]      toCnt, toCntNext;

    logic                 rxClearQ;
    logic                 wrenQ, wrenNext;
    logic [ADDR_SIZE-1:0] addrQ, addrNext;
    logic [31:0]          dataQ, dataNext;

    logic                 accept;
    logic                 timedState;
    logic [16:0]          lenFull;
    logic [16:0]          idxInc;

    // A pending rxClear means the UART has not yet dropped rxReady for the byte just taken.
    assign accept     = bus.rxReady && !rxClearQ;
    assign timedState = (state == LEN_HI) || (state == LEN_LO) || (state == DATA) || (state == CHKSUM);
    assign lenFull    = {1'b0, lenHi, bus.rxData};
    assign idxInc     = 17'(wordIdx) + 17'd1;

    assign bus.rxClear     = rxClearQ;
    assign bus.instWren    = wrenQ;
    assign bus.instAddress = addrQ;
    assign bus.instData    = dataQ;
    assign bus.cpuHold     = (state != DONE);
    assign bus.done        = (state == DONE);
    assign bus.error       = (state == ERROR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= WAIT_SYNC;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext    = state;
        lenHiNext    = lenHi;
        wordCntNext  = wordCnt;
        wordIdxNext  = wordIdx;
        byteCntNext  = byteCnt;
        shiftNext    = shiftReg;
        checksumNext = checksum;
        wrenNext     = 1'b0;
        addrNext     = addrQ;
        dataNext     = dataQ;
        toCntNext    = '0;

        if (timedState && !accept) begin
            toCntNext = toCnt + TO_W'(1);
        end

        case (state)
            WAIT_SYNC, ERROR: begin
                if (accept && (bus.rxData == SYNC_BYTE)) begin
                    stateNext    = LEN_HI;
                    checksumNext = '0;
                    wordIdxNext  = '0;
                    byteCntNext  = '0;
                end
            end
            LEN_HI: begin
                if (accept) begin
                    lenHiNext = bus.rxData;
                    stateNext = LEN_LO;
                end
            end
            LEN_LO: begin
                if (accept) begin
                    wordCntNext = lenFull[15:0];
                    if (lenFull > MAX_WORDS) begin
                        stateNext = ERROR;
                    end else if (lenFull == 17'd0) begin
                        stateNext = CHKSUM;
                    end else begin
                        stateNext = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    checksumNext = checksum ^ bus.rxData;
                    shiftNext    = {shiftReg[15:0], bus.rxData};
                    byteCntNext  = byteCnt + 2'd1;
                    if (byteCnt == 2'd3) begin
                        wrenNext    = 1'b1;
                        addrNext    = wordIdx[ADDR_SIZE-1:0];
                        dataNext    = {shiftReg, bus.rxData};
                        wordIdxNext = wordIdx + (ADDR_SIZE + 1)'(1);
                        if (idxInc == {1'b0, wordCnt}) begin
                            stateNext = CHKSUM;
                        end
                    end
                end
            end
            CHKSUM: begin
                if (accept) begin
                    stateNext = (bus.rxData == checksum) ? DONE : ERROR;
                end
            end
            DONE: begin
                // Terminal: bytes are still consumed by the rxClear path but ignored here.
            end
            default: begin
                stateNext = WAIT_SYNC;
            end
        endcase

        // An accepted byte in the limit cycle wins, so only an idle cycle can time out.
        if (timedState && !accept && (toCnt == TO_LAST)) begin
            stateNext = ERROR;
            toCntNext = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lenHi    <= '0;
            wordCnt  <= '0;
            wordIdx  <= '0;
            byteCnt  <= '0;
            shiftReg <= '0;
            checksum <= '0;
            toCnt    <= '0;
            rxClearQ <= 1'b0;
            wrenQ    <= 1'b0;
            addrQ    <= '0;
            dataQ    <= '0;
        end else begin
            lenHi    <= lenHiNext;
            wordCnt  <= wordCntNext;
            wordIdx  <= wordIdxNext;
            byteCnt  <= byteCntNext;
            shiftReg <= shiftNext;
            checksum <= checksumNext;
            toCnt    <= toCntNext;
            rxClearQ <= accept;
            wrenQ    <= wrenNext;
            addrQ    <= addrNext;
            dataQ    <= dataNext;
        end
    end

endmodule
